// File: rtl/gauss_img_pkg.sv
// Shared defaults, FSM encoding and sizing helper for the Gaussian image source port.
package gauss_img_pkg;

  localparam int IMG_W_DEF   = 256;
  localparam int IMG_H_DEF   = 256;
  localparam int COORD_W_DEF = 10;
  localparam int RD_LAT      = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_READY = 2'd2
  } state_t;

  // Counter/address width that never collapses to zero bits for tiny dimensions.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/img_ram_sdp.sv
// Simple dual-port pixel RAM: one write port, one registered read port (1-cycle latency).
module img_ram_sdp #(
  parameter int DEPTH = 65536,
  parameter int AW    = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_dt,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_dt
);

  logic [7:0] mem [DEPTH];

  // NOTE: the array has no reset so it maps onto block RAM; contents are defined only by writes.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_dt;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     rd_dt <= '0;
    else if (rd_en) rd_dt <= mem[rd_addr];
  end

endmodule

// File: rtl/gauss_img_src_port.sv
// Image source port: raster load into pixel RAM, then clamped (border-replicate) reads
// with a fixed two-cycle, fully pipelined latency.
module gauss_img_src_port
  import gauss_img_pkg::*;
#(
  parameter int IMG_W   = IMG_W_DEF,
  parameter int IMG_H   = IMG_H_DEF,
  parameter int COORD_W = COORD_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ld_start,
  input  logic               ld_vl,
  input  logic [7:0]         ld_dt,
  output logic               ld_done,
  output logic               ready,
  input  logic               rd_en,
  input  logic [COORD_W-1:0] rd_px,
  input  logic [COORD_W-1:0] rd_py,
  output logic [7:0]         rd_dt,
  output logic               rd_vl
);

  localparam int DEPTH = IMG_W * IMG_H;
  localparam int AW    = clog2_min1(DEPTH);
  localparam int XW    = clog2_min1(IMG_W);
  localparam int YW    = clog2_min1(IMG_H);

  state_t            state_q, state_d;
  logic [XW-1:0]     x_q;
  logic [YW-1:0]     y_q;
  logic              ld_done_q;
  logic              wr_en, x_last, last_px;
  logic [AW-1:0]     wr_addr;

  logic [XW-1:0]     cx;
  logic [YW-1:0]     cy;
  logic              rd_acc;
  logic [AW-1:0]     rd_addr_q;
  logic [RD_LAT-1:0] vld_q;

  // A restart pulse takes priority over a pixel arriving in the same cycle.
  assign wr_en   = (state_q == ST_LOAD) && ld_vl && !ld_start;
  assign x_last  = (x_q == XW'(IMG_W - 1));
  assign last_px = x_last && (y_q == YW'(IMG_H - 1));
  assign wr_addr = AW'(y_q) * AW'(IMG_W) + AW'(x_q);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (ld_start) state_d = ST_LOAD;
      ST_LOAD:  if (wr_en && last_px) state_d = ST_READY;
      ST_READY: if (ld_start) state_d = ST_LOAD;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q       <= '0;
      y_q       <= '0;
      ld_done_q <= 1'b0;
    end else begin
      ld_done_q <= wr_en && last_px;
      if (ld_start) begin
        x_q <= '0;
        y_q <= '0;
      end else if (wr_en) begin
        if (x_last) begin
          x_q <= '0;
          y_q <= last_px ? '0 : y_q + 1'b1;
        end else begin
          x_q <= x_q + 1'b1;
        end
      end
    end
  end

  assign ld_done = ld_done_q;
  assign ready   = (state_q == ST_READY);
  assign rd_acc  = rd_en && ready;

  // Sign bit set means negative; otherwise an unsigned compare against the edge suffices.
  always_comb begin
    cx = rd_px[XW-1:0];
    cy = rd_py[YW-1:0];
    if (rd_px[COORD_W-1])                   cx = '0;
    else if (rd_px > COORD_W'(IMG_W - 1))   cx = XW'(IMG_W - 1);
    if (rd_py[COORD_W-1])                   cy = '0;
    else if (rd_py > COORD_W'(IMG_H - 1))   cy = YW'(IMG_H - 1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_addr_q <= '0;
      vld_q     <= '0;
    end else begin
      vld_q <= {vld_q[RD_LAT-2:0], rd_acc};
      if (rd_acc) rd_addr_q <= AW'(cy) * AW'(IMG_W) + AW'(cx);
    end
  end

  assign rd_vl = vld_q[RD_LAT-1];

  img_ram_sdp #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_dt   (ld_dt),
    .rd_en   (vld_q[0]),
    .rd_addr (rd_addr_q),
    .rd_dt   (rd_dt)
  );

endmodule

// File: doc/gauss_img_src_port.md
GAUSS_IMG_SRC_PORT -- requirements
Module: gauss_img_src_port

Interface
REQ-001 Parameter IMG_W, default 256, image width in pixels.
REQ-002 Parameter IMG_H, default 256, image height in pixels.
REQ-003 Parameter COORD_W, default 10, width of the signed two's-complement read coordinates.
REQ-004 Clocking shall be one clock with an asynchronous, active-low reset.
REQ-005 Port clk  in  1  system clock; all logic on its rising edge.
REQ-006 Port rst_n  in  1  asynchronous active-low reset.
REQ-007 Port ld_start  in  1  one-cycle pulse that begins an image load.
REQ-008 Port ld_vl  in  1  load pixel valid.
REQ-009 Port ld_dt  in  8  load pixel data, raster order.
REQ-010 Port ld_done  out  1  one-cycle pulse when the last pixel is written.
REQ-011 Port ready  out  1  high while the image is loaded and reads are served.
REQ-012 Port rd_en  in  1  read request.
REQ-013 Port rd_px  in  COORD_W  signed x coordinate, range [-255,510].
REQ-014 Port rd_py  in  COORD_W  signed y coordinate, range [-255,510].
REQ-015 Port rd_dt  out  8  read data.
REQ-016 Port rd_vl  out  1  read data valid.

Function
REQ-017 The FSM shall have the states IDLE, LOAD and READY, with IDLE entered on reset.
REQ-018 IDLE->LOAD on ld_start; LOAD->READY on the cycle the IMG_W*IMG_H-th pixel is accepted; READY->LOAD on ld_start.
REQ-019 An ld_start pulse in LOAD shall restart the load, clearing the x/y counters to 0 with no ld_done.
REQ-020 In LOAD, each cycle with ld_vl=1 shall write ld_dt at address y*IMG_W+x and then advance x; x wraps at IMG_W-1 to 0 with y incremented.
REQ-021 ld_vl=0 in LOAD shall hold the counters; ld_vl outside LOAD shall be ignored.
REQ-022 ld_done shall pulse for exactly one cycle, registered, in the cycle after the final write, coincident with ready rising.
REQ-023 ready shall be 1 only in READY.
REQ-024 rd_en shall be accepted only when ready=1; otherwise it is ignored and produces no rd_vl.
REQ-025 Each coordinate shall clamp as: negative -> 0; greater than IMG_W-1 (x) or IMG_H-1 (y) -> that limit; otherwise unchanged (border replicate).
REQ-026 Read latency shall be fixed at 2 cycles: stage 1 registers the clamped address, stage 2 registers the RAM output; rd_vl=1 exactly two cycles after an accepted rd_en.
REQ-027 The read path shall be fully pipelined, accepting one read per cycle with back-to-back rd_en giving back-to-back rd_vl, in order.
REQ-028 rd_dt shall hold its last value when rd_vl=0.
REQ-029 On READY->LOAD, reads already accepted shall complete normally, with at most 2 trailing rd_vl.
REQ-030 In the same cycle as the READY->LOAD transition, a simultaneous rd_en shall still be accepted because ready was 1 in that cycle.
REQ-031 A load write and a read in the same cycle to the same address cannot occur, because reads are gated by READY.

Reset
REQ-032 While rst_n=0: state=IDLE, x/y counters=0, ready=0, ld_done=0, rd_vl=0, rd_dt=0 and pipeline valid bits cleared.
REQ-033 Reset asserted mid-load or mid-read shall abort immediately; partial load data is discarded and a new ld_start is required.
REQ-034 Pixel RAM contents shall not be reset.

Structure
REQ-035 Package gauss_img_pkg shall hold IMG_W, IMG_H, COORD_W defaults, the state encoding and the read latency constant RD_LAT=2.
REQ-036 Sub-module img_ram_sdp shall be a simple dual-port synchronous RAM of IMG_W*IMG_H x 8, with one write port, one read port and 1-cycle read latency.
REQ-037 The top level shall contain the FSM, load counters, clamp logic and the valid pipeline.

Verification
REQ-038 Reset then ld_start, stream 65536 pixels with data=(x+y)&0xFF -> ld_done pulses once, ready=1 in the next-cycle relationship required by REQ-022.
REQ-039 Read (0,0), (255,255), (17,3) back-to-back -> rd_dt=0x00,0xFE,0x14 on three consecutive cycles, each 2 cycles after its request.
REQ-040 Read (-2,5), (257,5), (3,-255), (3,510) -> returns pixels (0,5), (255,5), (3,0), (3,255).
REQ-041 rd_en while in IDLE or LOAD -> rd_vl stays 0; insert ld_vl gaps during load -> data lands at the correct addresses.
REQ-042 Issue rd_en in the ld_start cycle while READY -> exactly one trailing rd_vl and ready=0 in the next cycle; a second ld_start mid-load restarts at (0,0).
REQ-043 Assert rst_n low at pixel 1000 of a load -> all outputs reach reset values asynchronously, and ready stays 0 until a full reload completes.
